// File: rtl/v810_intc.sv
// v810 interrupt controller: 16 maskable sources plus NMI, registered level request.
// Optional define V810_INTC_SYNC_EN adds two-flop input synchronisers.
module v810_intc #(
  parameter int          NMI_PULSE = 4,
  parameter logic [15:0] IEN_RESET = 16'h0
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [15:0] IRQ,
  input  logic        NMI_SRC,
  input  logic        REG_CEn,
  input  logic        REG_WEn,
  input  logic [1:0]  REG_A,
  input  logic [15:0] REG_DI,
  output logic [15:0] REG_DO,
  output logic        INT,
  output logic [3:0]  INTVn,
  output logic        NMIn
);

  localparam int CW = $clog2(NMI_PULSE + 1);

  logic [15:0]   ien;
  logic [15:0]   imode;
  logic [15:0]   latch;
  logic [15:0]   latch_nx;
  logic [15:0]   irq_s;
  logic [15:0]   irq_p;
  logic [15:0]   pend;
  logic [15:0]   req;
  logic [15:0]   rd_data;
  logic [3:0]    lvl;
  logic          nmi_s;
  logic          nmi_p;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          wr;
  logic          rd;

`ifdef V810_INTC_SYNC_EN
  logic [15:0] irq_m;
  logic        nmi_m;

  // Two-flop synchronisers for asynchronous sources.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      irq_m <= '0;
      irq_s <= '0;
      nmi_m <= 1'b0;
      nmi_s <= 1'b0;
    end else if (CE) begin
      irq_m <= IRQ;
      irq_s <= irq_m;
      nmi_m <= NMI_SRC;
      nmi_s <= nmi_m;
    end
  end
`else
  assign irq_s = IRQ;
  assign nmi_s = NMI_SRC;
`endif

  assign wr   = ~REG_CEn & ~REG_WEn;
  assign rd   = ~REG_CEn & REG_WEn;
  assign pend = (imode & latch) | (~imode & irq_s);
  assign req  = pend & ien;

  // Highest set request bit wins; zero when nothing requests.
  always_comb begin
    lvl = '0;
    for (int i = 0; i < 16; i++) begin
      if (req[i]) lvl = 4'(i);
    end
  end

  // Edge latches: host clears first, a new edge then sets over it.
  always_comb begin
    latch_nx = latch;
    if (wr && REG_A == 2'd2) latch_nx = latch_nx & ~REG_DI;
    if (wr && REG_A == 2'd1) latch_nx = latch_nx & REG_DI;
    latch_nx = latch_nx | (irq_s & ~irq_p & imode);
  end

  // NMI pulse counter: reload on a rising edge, else run down to zero.
  always_comb begin
    if (nmi_s && !nmi_p) cnt_nx = CW'(NMI_PULSE);
    else if (cnt != '0)  cnt_nx = cnt - 1'b1;
    else                 cnt_nx = cnt;
  end

  // Register read mux; ISTAT reflects the registered outputs.
  always_comb begin
    case (REG_A)
      2'd0:    rd_data = ien;
      2'd1:    rd_data = imode;
      2'd2:    rd_data = pend;
      default: rd_data = {11'b0, INT, ~INTVn};
    endcase
  end

  // Main state and registered outputs, all gated by CE.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      ien    <= IEN_RESET;
      imode  <= '0;
      latch  <= '0;
      irq_p  <= '0;
      nmi_p  <= 1'b0;
      cnt    <= '0;
      INT    <= 1'b0;
      INTVn  <= 4'hF;
      NMIn   <= 1'b1;
      REG_DO <= '0;
    end else if (CE) begin
      irq_p <= irq_s;
      nmi_p <= nmi_s;
      latch <= latch_nx;
      cnt   <= cnt_nx;
      INT   <= |req;
      INTVn <= ~lvl;
      NMIn  <= (cnt_nx == '0);
      if (wr && REG_A == 2'd0) ien <= REG_DI;
      if (wr && REG_A == 2'd1) imode <= REG_DI;
      if (rd) REG_DO <= rd_data;
    end
  end

endmodule

// File: tb/tb_v810_intc.sv
// Directed bench for v810_intc: level/edge requests, masking, NMI pulse, reset.
// Latencies adapt to whether V810_INTC_SYNC_EN is defined.
module tb_v810_intc;

`ifdef V810_INTC_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESn;
  logic        CE;
  logic [15:0] IRQ;
  logic        NMI_SRC;
  logic        REG_CEn;
  logic        REG_WEn;
  logic [1:0]  REG_A;
  logic [15:0] REG_DI;
  logic [15:0] REG_DO;
  logic        INT;
  logic [3:0]  INTVn;
  logic        NMIn;

  int checks = 0;
  int errors = 0;

  v810_intc dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .IRQ(IRQ), .NMI_SRC(NMI_SRC),
    .REG_CEn(REG_CEn), .REG_WEn(REG_WEn), .REG_A(REG_A), .REG_DI(REG_DI),
    .REG_DO(REG_DO), .INT(INT), .INTVn(INTVn), .NMIn(NMIn)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] ien;
    logic [15:0] irq;
    logic        e_int;
    logic [3:0]  e_vn;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    REG_CEn = 1'b0; REG_WEn = 1'b0; REG_A = a; REG_DI = d;
    tick();
    REG_CEn = 1'b1; REG_WEn = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    REG_CEn = 1'b0; REG_WEn = 1'b1; REG_A = a;
    tick();
    REG_CEn = 1'b1;
    d = REG_DO;
  endtask

  task automatic nmi_run(input int p2, output int low);
    low = 0;
    for (int i = 1; i <= 20; i++) begin
      NMI_SRC = (i == 1 || i == p2);
      tick();
      if (NMIn == 1'b0) low++;
    end
    NMI_SRC = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    int low;

    vt[0] = '{16'hFFFF, 16'h0180, 1'b1, 4'h7};
    vt[1] = '{16'hFFFF, 16'h0080, 1'b1, 4'h8};
    vt[2] = '{16'hFFFF, 16'h0000, 1'b0, 4'hF};
    vt[3] = '{16'hFFFF, 16'h8001, 1'b1, 4'h0};
    vt[4] = '{16'hFFFF, 16'h0001, 1'b1, 4'hF};
    vt[5] = '{16'h0100, 16'h0180, 1'b1, 4'h7};
    vt[6] = '{16'h00FF, 16'hFF00, 1'b0, 4'hF};
    vt[7] = '{16'h0F0F, 16'hFFFF, 1'b1, 4'h4};

    RESn = 1'b0; CE = 1'b1; IRQ = '0; NMI_SRC = 1'b0;
    REG_CEn = 1'b1; REG_WEn = 1'b1; REG_A = '0; REG_DI = '0;
    #12;
    chk("rst_int", {15'b0, INT}, 16'h0);
    chk("rst_intvn", {12'b0, INTVn}, 16'hF);
    chk("rst_nmin", {15'b0, NMIn}, 16'h1);
    chk("rst_do", REG_DO, 16'h0);
    RESn = 1'b1;
    tick();
    rd(2'd0, d);
    chk("rst_ien", d, 16'h0000);

    // Level latency: not yet after SD edges, present after SD+1.
    wr(2'd0, 16'hFFFF);
    tick(2);
    IRQ = 16'h0180;
    tick(SD);
    chk("lat_before", {15'b0, INT}, 16'h0);
    tick();
    chk("lat_int", {15'b0, INT}, 16'h1);
    chk("lat_vn", {12'b0, INTVn}, 16'h7);

    // Table of level-mode patterns.
    for (int i = 0; i < 8; i++) begin
      wr(2'd0, vt[i].ien);
      IRQ = vt[i].irq;
      tick(SD + 2);
      chk($sformatf("vec%0d_int", i), {15'b0, INT}, {15'b0, vt[i].e_int});
      chk($sformatf("vec%0d_vn", i), {12'b0, INTVn}, {12'b0, vt[i].e_vn});
      rd(2'd3, d);
      chk($sformatf("vec%0d_istat", i), d, {11'b0, vt[i].e_int, ~vt[i].e_vn});
    end

    // Clock enable low freezes everything, synchronisers included.
    IRQ = '0;
    wr(2'd0, 16'hFFFF);
    tick(SD + 2);
    CE = 1'b0;
    IRQ = 16'h0010;
    tick(5);
    chk("ce_hold", {15'b0, INT}, 16'h0);
    CE = 1'b1;
    tick(SD + 1);
    chk("ce_int", {15'b0, INT}, 16'h1);
    chk("ce_vn", {12'b0, INTVn}, 16'hB);
    IRQ = '0;

    // Edge mode: a one-cycle pulse is latched and held.
    wr(2'd0, 16'h0080);
    wr(2'd1, 16'h0080);
    tick(SD + 2);
    IRQ = 16'h0080;
    tick();
    IRQ = '0;
    tick(SD + 1);
    chk("edge_int", {15'b0, INT}, 16'h1);
    chk("edge_vn", {12'b0, INTVn}, 16'h8);
    rd(2'd2, d);
    chk("edge_pend", d, 16'h0080);
    tick(3);
    chk("edge_held", {15'b0, INT}, 16'h1);
    wr(2'd2, 16'h0080);
    chk("w1c_same", {15'b0, INT}, 16'h1);
    tick();
    chk("w1c_int", {15'b0, INT}, 16'h0);
    rd(2'd2, d);
    chk("w1c_pend", d, 16'h0000);

    // Clear coincident with a new edge: the set wins.
    IRQ = 16'h0080;
    tick(SD);
    wr(2'd2, 16'h0080);
    IRQ = '0;
    rd(2'd2, d);
    chk("coinc_pend", d, 16'h0080);
    wr(2'd1, 16'h0000);
    rd(2'd2, d);
    chk("imode_clr", d, 16'h0000);

    // Masking: IEN write removes the request one edge later.
    wr(2'd0, 16'h0100);
    IRQ = 16'h0180;
    tick(SD + 2);
    chk("msk_int", {15'b0, INT}, 16'h1);
    chk("msk_vn", {12'b0, INTVn}, 16'h7);
    wr(2'd0, 16'h0000);
    chk("msk_same", {15'b0, INT}, 16'h1);
    tick();
    chk("msk_int0", {15'b0, INT}, 16'h0);
    chk("msk_vn0", {12'b0, INTVn}, 16'hF);
    rd(2'd2, d);
    chk("msk_pend", d, 16'h0180);
    IRQ = '0;
    tick(SD + 2);

    // NMI: single pulse, then retrigger inside the window.
    nmi_run(0, low);
    chk("nmi_len", 16'(low), 16'd4);
    chk("nmi_end", {15'b0, NMIn}, 16'h1);
    nmi_run(3, low);
    chk("nmi_retrig", 16'(low), 16'd6);

    // Asynchronous reset during an active request and NMI pulse.
    wr(2'd0, 16'hFFFF);
    IRQ = 16'h0020;
    NMI_SRC = 1'b1;
    tick();
    NMI_SRC = 1'b0;
    rd(2'd0, d);
    tick(SD + 1);
    chk("pre_int", {15'b0, INT}, 16'h1);
    chk("pre_nmin", {15'b0, NMIn}, 16'h0);
    #2;
    RESn = 1'b0;
    #1;
    chk("ar_int", {15'b0, INT}, 16'h0);
    chk("ar_vn", {12'b0, INTVn}, 16'hF);
    chk("ar_nmin", {15'b0, NMIn}, 16'h1);
    chk("ar_do", REG_DO, 16'h0);
    IRQ = '0;
    tick();
    RESn = 1'b1;
    tick();
    rd(2'd0, d);
    chk("ar_ien", d, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
